// File: rtl/nrisc_loader_pkg.sv
// Shared types and default constants for the nRisc byte-stream program loader.
package nrisc_loader_pkg;

  localparam int          LOADER_ADDR_W = 8;
  localparam logic [7:0]  DEF_CMD_IMEM  = 8'hA5;
  localparam logic [7:0]  DEF_CMD_DMEM  = 8'h5A;
  localparam logic [7:0]  DEF_CMD_RUN   = 8'hC3;
  localparam logic [7:0]  DEF_CMD_STOP  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CKSUM,
    ST_RUN,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/nrisc_prog_loader.sv
// Framed byte-stream loader: fills imem/dmem while holding the nRisc core in reset.
// Define NRISC_LOADER_CKSUM_EN to require a trailing checksum byte on every load frame.
import nrisc_loader_pkg::*;

module nrisc_prog_loader #(
  parameter int         ADDR_W   = LOADER_ADDR_W,
  parameter logic [7:0] CMD_IMEM = DEF_CMD_IMEM,
  parameter logic [7:0] CMD_DMEM = DEF_CMD_DMEM,
  parameter logic [7:0] CMD_RUN  = DEF_CMD_RUN,
  parameter logic [7:0] CMD_STOP = DEF_CMD_STOP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_wdata,
  output logic              cpu_reset,
  output logic              err,
  output logic [7:0]        frame_cnt
);

`ifdef NRISC_LOADER_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  loader_state_t     state, state_next;
  logic              tgt_dmem, tgt_dmem_next;
  logic [ADDR_W-1:0] addr_cnt, addr_cnt_next;
  logic [7:0]        remain, remain_next;
  logic [7:0]        sum, sum_next;
  logic              cpu_reset_next, err_next;
  logic [7:0]        frame_cnt_next;
  logic              imem_we_next, dmem_we_next;
  logic [ADDR_W-1:0] imem_addr_next, dmem_addr_next;
  logic [7:0]        imem_wdata_next, dmem_wdata_next;
  logic              payload_done;
  logic              accept;

  // Ready is held low during reset and permanently after a protocol error.
  assign in_ready = RESET && (state != ST_ERR);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      tgt_dmem   <= 1'b0;
      addr_cnt   <= '0;
      remain     <= '0;
      sum        <= '0;
      cpu_reset  <= 1'b1;
      err        <= 1'b0;
      frame_cnt  <= '0;
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      imem_addr  <= '0;
      dmem_addr  <= '0;
      imem_wdata <= '0;
      dmem_wdata <= '0;
    end else begin
      state      <= state_next;
      tgt_dmem   <= tgt_dmem_next;
      addr_cnt   <= addr_cnt_next;
      remain     <= remain_next;
      sum        <= sum_next;
      cpu_reset  <= cpu_reset_next;
      err        <= err_next;
      frame_cnt  <= frame_cnt_next;
      imem_we    <= imem_we_next;
      dmem_we    <= dmem_we_next;
      imem_addr  <= imem_addr_next;
      dmem_addr  <= dmem_addr_next;
      imem_wdata <= imem_wdata_next;
      dmem_wdata <= dmem_wdata_next;
    end
  end

  always_comb begin
    state_next      = state;
    tgt_dmem_next   = tgt_dmem;
    addr_cnt_next   = addr_cnt;
    remain_next     = remain;
    sum_next        = sum;
    cpu_reset_next  = cpu_reset;
    err_next        = err;
    frame_cnt_next  = frame_cnt;
    imem_we_next    = 1'b0;
    dmem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    dmem_addr_next  = dmem_addr;
    imem_wdata_next = imem_wdata;
    dmem_wdata_next = dmem_wdata;
    payload_done    = 1'b0;

    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
            tgt_dmem_next = (in_data == CMD_DMEM);
            state_next    = ST_ADDR;
          end else if (in_data == CMD_RUN) begin
            cpu_reset_next = 1'b0;
            state_next     = ST_RUN;
          end else if (in_data != CMD_STOP) begin
            err_next   = 1'b1;
            state_next = ST_ERR;
          end
        end
        ST_ADDR: begin
          addr_cnt_next = ADDR_W'(in_data);
          sum_next      = in_data;
          state_next    = ST_LEN;
        end
        ST_LEN: begin
          remain_next = in_data;
          sum_next    = sum + in_data;
          if (in_data == 8'd0) payload_done = 1'b1;
          else                 state_next   = ST_DATA;
        end
        ST_DATA: begin
          if (tgt_dmem) begin
            dmem_we_next    = 1'b1;
            dmem_addr_next  = addr_cnt;
            dmem_wdata_next = in_data;
          end else begin
            imem_we_next    = 1'b1;
            imem_addr_next  = addr_cnt;
            imem_wdata_next = in_data;
          end
          addr_cnt_next = addr_cnt + ADDR_W'(1);
          remain_next   = remain - 8'd1;
          sum_next      = sum + in_data;
          if (remain == 8'd1) payload_done = 1'b1;
        end
        ST_CKSUM: begin
          if ((sum + in_data) == 8'd0) begin
            frame_cnt_next = frame_cnt + 8'd1;
            state_next     = ST_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERR;
          end
        end
        ST_RUN: begin
          if (in_data == CMD_STOP) begin
            cpu_reset_next = 1'b1;
            state_next     = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (payload_done) begin
      if (CKSUM_EN) begin
        state_next = ST_CKSUM;
      end else begin
        frame_cnt_next = frame_cnt + 8'd1;
        state_next     = ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_prog_loader.sv
// Randomised self-checking bench for nrisc_prog_loader against a byte-stream frame parser model.
// Checksum scenarios are exercised when NRISC_LOADER_CKSUM_EN is defined.
module tb_nrisc_prog_loader;
  import nrisc_loader_pkg::*;

`ifdef NRISC_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, imem_we, dmem_we, cpu_reset, err;
  logic [7:0] imem_addr, dmem_addr, imem_wdata, dmem_wdata, frame_cnt;

  nrisc_prog_loader dut (
    .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_reset(cpu_reset), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int bad_load = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed writes, captured away from the clock edge.
  logic [15:0] got_i[$], got_d[$];
  always @(negedge CLK) begin
    if (imem_we) got_i.push_back({imem_addr, imem_wdata});
    if (dmem_we) got_d.push_back({dmem_addr, dmem_wdata});
    if ((imem_we || dmem_we) && !cpu_reset) bad_load++;
  end

  // Reference model: parses whole byte streams into expected writes and status.
  logic [15:0] exp_i[$], exp_d[$];
  logic [7:0]  exp_frames = 8'd0;
  bit          exp_run = 1'b0;
  bit          exp_err = 1'b0;

  task automatic model_apply(input logic [7:0] s[$]);
    int i, n, tot;
    logic [7:0] c, a, d, ak;
    i = 0;
    while (i < s.size() && !exp_err) begin
      c = s[i]; i++;
      if (exp_run) begin
        if (c == DEF_CMD_STOP) exp_run = 1'b0;
      end else if (c == DEF_CMD_RUN) begin
        exp_run = 1'b1;
      end else if (c == DEF_CMD_STOP) begin
        // ignored while idle
      end else if (c == DEF_CMD_IMEM || c == DEF_CMD_DMEM) begin
        a = s[i]; n = int'(s[i+1]); i += 2;
        tot = int'(a) + n;
        for (int k = 0; k < n; k++) begin
          d = s[i+k];
          tot += int'(d);
          ak = 8'((int'(a) + k) % 256);
          if (c == DEF_CMD_IMEM) exp_i.push_back({ak, d});
          else                   exp_d.push_back({ak, d});
        end
        i += n;
        if (CK) begin
          tot += int'(s[i]); i++;
          if (tot % 256 != 0) exp_err = 1'b1;
        end
        if (!exp_err) exp_frames = 8'((int'(exp_frames) + 1) % 256);
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic mk_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] p[$],
                          output logic [7:0] s[$]);
    int tot;
    s = {};
    s.push_back(cmd); s.push_back(a); s.push_back(8'(p.size()));
    tot = int'(a) + p.size();
    foreach (p[k]) begin s.push_back(p[k]); tot += int'(p[k]); end
    if (CK) s.push_back(8'((256 - (tot % 256)) % 256));
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
    bit r;
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge CLK); #1; end
    in_data = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK); r = in_ready;
      @(posedge CLK); #1;
      if (r) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_all(input logic [7:0] s[$], input int max_gap);
    bit ok;
    foreach (s[k]) begin
      send_byte(s[k], max_gap, ok);
      chk("accept", 32'(ok), 32'd1);
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic scoreboard(input string tag);
    chk({tag, "_imem_n"}, 32'(got_i.size()), 32'(exp_i.size()));
    chk({tag, "_dmem_n"}, 32'(got_d.size()), 32'(exp_d.size()));
    foreach (exp_i[k]) if (k < got_i.size()) chk({tag, "_imem_wr"}, 32'(got_i[k]), 32'(exp_i[k]));
    foreach (exp_d[k]) if (k < got_d.size()) chk({tag, "_dmem_wr"}, 32'(got_d[k]), 32'(exp_d[k]));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err || !exp_run));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    $display("txn %s: frames=%0d imem_wr=%0d dmem_wr=%0d", tag, frame_cnt, got_i.size(), got_d.size());
    got_i = {}; got_d = {}; exp_i = {}; exp_d = {};
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b0;
    @(negedge CLK);
    chk({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_rst_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_rst_err_cnt"}, {23'd0, err, frame_cnt}, 32'd0);
    chk({tag, "_rst_we"}, {30'd0, imem_we, dmem_we}, 32'd0);
    chk({tag, "_rst_bus"}, {imem_addr, imem_wdata, dmem_addr, dmem_wdata}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    exp_frames = 8'd0; exp_run = 1'b0; exp_err = 1'b0;
    got_i = {}; got_d = {}; exp_i = {}; exp_d = {};
    $display("txn %s: reset", tag);
  endtask

  initial begin
    logic [7:0] s[$], p[$];
    bit ok;
    int len;

    repeat (2) @(posedge CLK); #1;
    do_reset("init");

    // Program image into imem.
    p = '{8'h88, 8'h91, 8'h9D, 8'h42, 8'hA1, 8'h24, 8'h43, 8'h2C, 8'hAE, 8'hC3, 8'h00};
    mk_frame(DEF_CMD_IMEM, 8'h00, p, s);
    model_apply(s); drive_all(s, 0); scoreboard("prog");

    // Data image, then release the core.
    p = '{8'h05, 8'h08, 8'hFF, 8'h01, 8'h0A};
    mk_frame(DEF_CMD_DMEM, 8'h00, p, s);
    model_apply(s); drive_all(s, 0); scoreboard("data");
    chk("pre_run_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(DEF_CMD_RUN, 0, ok);
    chk("run_accept", 32'(ok), 32'd1);
    chk("run_fall", 32'(cpu_reset), 32'd0);
    s = '{DEF_CMD_RUN}; model_apply(s);

    // Bytes dropped in RUN, then STOP and an empty frame.
    s = '{8'hA5, 8'h12};
    model_apply(s); drive_all(s, 1);
    chk("run_still", 32'(cpu_reset), 32'd0);
    send_byte(DEF_CMD_STOP, 0, ok);
    chk("stop_rise", 32'(cpu_reset), 32'd1);
    s = '{DEF_CMD_STOP}; model_apply(s);
    p = {};
    mk_frame(DEF_CMD_IMEM, 8'h00, p, s);
    model_apply(s); drive_all(s, 0); scoreboard("run_stop");

    // Address wrap with random valid gaps.
    p = '{8'h11, 8'h22, 8'h33};
    mk_frame(DEF_CMD_IMEM, 8'hFE, p, s);
    model_apply(s); drive_all(s, 3); scoreboard("wrap");

    // Random frames and run/stop sequences.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) == 7) begin
        s = '{DEF_CMD_RUN};
        repeat ($urandom_range(0, 4)) begin
          logic [7:0] j;
          j = 8'($urandom);
          if (j == DEF_CMD_STOP) j = 8'h00;
          s.push_back(j);
        end
        s.push_back(DEF_CMD_STOP);
      end else begin
        p = {};
        len = int'($urandom_range(0, 12));
        repeat (len) p.push_back(8'($urandom));
        mk_frame($urandom_range(0, 1) ? DEF_CMD_DMEM : DEF_CMD_IMEM, 8'($urandom), p, s);
      end
      model_apply(s); drive_all(s, int'($urandom_range(0, 2))); scoreboard($sformatf("rnd%0d", it));
    end

    // Frame counter wrap through 255.
    s = {};
    p = {};
    for (int f = 0; f < 257; f++) begin
      logic [7:0] e[$];
      mk_frame(DEF_CMD_DMEM, 8'h00, p, e);
      foreach (e[k]) s.push_back(e[k]);
    end
    model_apply(s); drive_all(s, 0); scoreboard("cnt_wrap");

    // Reset in the middle of a payload keeps issued writes and returns to IDLE.
    s = '{DEF_CMD_IMEM, 8'h10, 8'h05, 8'h11, 8'h22};
    drive_all(s, 0);
    chk("mid_wr_n", 32'(got_i.size()), 32'd2);
    if (got_i.size() == 2) chk("mid_wr1", 32'(got_i[1]), 32'h1122);
    do_reset("mid");
    p = '{8'h77};
    mk_frame(DEF_CMD_DMEM, 8'h40, p, s);
    model_apply(s); drive_all(s, 0); scoreboard("after_mid");

`ifdef NRISC_LOADER_CKSUM_EN
    s = '{8'h5A, 8'h00, 8'h01, 8'h05, 8'hFA};
    model_apply(s); drive_all(s, 0); scoreboard("ck_good");
    s = '{8'h5A, 8'h00, 8'h01, 8'h05, 8'hFB};
    model_apply(s); drive_all(s, 0); scoreboard("ck_bad");
    do_reset("ck_rst");
`endif

    // Illegal command byte is terminal until reset.
    s = '{8'h7E};
    model_apply(s); drive_all(s, 0); scoreboard("bad_cmd");
    chk("err_ready", 32'(in_ready), 32'd0);
    send_byte(DEF_CMD_DMEM, 0, ok);
    chk("err_ignore", 32'(ok), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset("err_rst");

    chk("load_while_run", 32'(bad_load), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
